// File: rtl/led_pattern_engine.sv
// led_pattern_engine: N-LED bar driver for the Whack-A-Mole game.
// Off / blink / chase / mole modes paced by a prescaled tick.
module led_pattern_engine #(
  parameter int NUM_LEDS  = 10,
  parameter int TICK_DIV  = 6_250_000,
  parameter int LIT_TICKS = 16,
  parameter int IDX_W     = $clog2(NUM_LEDS)
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  input  logic                mode_load,
  input  logic [IDX_W-1:0]    mole_idx,
  input  logic                mole_hit,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                tick,
  output logic                mole_timeout,
  output logic                mole_hit_ack
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] POS_MAX = IDX_W'(NUM_LEDS - 1);
  localparam logic [IDX_W:0]   N_LEDS  = (IDX_W+1)'(NUM_LEDS);
  localparam logic [15:0]      LIFE_MAX = 16'(LIT_TICKS - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_BLINK,
    S_CHASE,
    S_MOLE_LIT,
    S_MOLE_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                phase, phase_nxt;
  logic [IDX_W-1:0]    pos, pos_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [15:0]         life, life_nxt;
  logic [NUM_LEDS-1:0] led_nxt;
  logic                to_nxt;
  logic                ack_nxt;

  function automatic logic [NUM_LEDS-1:0] blink_pat(input logic ph);
    logic [NUM_LEDS-1:0] p;
    for (int i = 0; i < NUM_LEDS; i++)
      p[i] = (i % 2 == 0) ? ph : ~ph;
    return p;
  endfunction

  // A load restarts the prescaler so the first tick is a full period away
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (mode_load) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_MAX);
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state        <= S_OFF;
      phase        <= 1'b0;
      pos          <= '0;
      idx          <= '0;
      life         <= '0;
      LEDR         <= '0;
      mole_timeout <= 1'b0;
      mole_hit_ack <= 1'b0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      pos          <= pos_nxt;
      idx          <= idx_nxt;
      life         <= life_nxt;
      LEDR         <= led_nxt;
      mole_timeout <= to_nxt;
      mole_hit_ack <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    pos_nxt   = pos;
    idx_nxt   = idx;
    life_nxt  = life;
    to_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    led_nxt   = '0;
    if (mode_load) begin
      phase_nxt = 1'b1;
      pos_nxt   = '0;
      life_nxt  = '0;
      idx_nxt   = mole_idx;
      unique case (mode)
        2'b00: state_nxt = S_OFF;
        2'b01: state_nxt = S_BLINK;
        2'b10: state_nxt = S_CHASE;
        2'b11: state_nxt = ({1'b0, mole_idx} >= N_LEDS) ?
                           S_MOLE_DONE : S_MOLE_LIT;
      endcase
    end else begin
      unique case (state)
        S_BLINK: if (tick) phase_nxt = ~phase;
        S_CHASE:
          if (tick)
            pos_nxt = (pos == POS_MAX) ? '0 : pos + IDX_W'(1);
        // A hit beats an expiring tick in the same cycle
        S_MOLE_LIT:
          if (mole_hit) begin
            state_nxt = S_MOLE_DONE;
            ack_nxt   = 1'b1;
          end else if (tick) begin
            if (life == LIFE_MAX) begin
              state_nxt = S_MOLE_DONE;
              to_nxt    = 1'b1;
            end else begin
              life_nxt = life + 16'd1;
            end
          end
        default: ;
      endcase
    end
    unique case (state_nxt)
      S_BLINK:    led_nxt = blink_pat(phase_nxt);
      S_CHASE:    led_nxt = NUM_LEDS'(1) << pos_nxt;
      S_MOLE_LIT: led_nxt = NUM_LEDS'(1) << idx_nxt;
      default:    led_nxt = '0;
    endcase
  end

endmodule
